i2s_audio_tx: RTL and testbench
===============================

Name: i2s_audio_tx

Overview:
Stereo I2S transmitter that consumes 16-bit signed PCM samples (sound-effect waveform, background music) and serializes them to the Pmod I2S DAC (CS4344).
- Generates MCLK, SCK and LRCK from the 100 MHz system clock.
- Latches one stereo sample pair per frame, applies mute and a volume shift, and shifts the data out MSB-first in standard I2S format.
- Sits between the audio sources / mixer and the top-level Pmod pins.

Parameters:
SAMPLE_W, 16, PCM sample width in bits; also the number of data bits sent per channel.
CNT_W, 10, width of the free-running master counter; one frame is 2^CNT_W clk cycles = 1024 cycles (~97.66 kHz).
VOL_W, 3, width of the volume attenuation input.

Ports:
clk  input  1  100 MHz system clock
rst  input  1  asynchronous, active-high reset
audio_l  input  SAMPLE_W  left sample, signed two's complement
audio_r  input  SAMPLE_W  right sample, signed two's complement
mute  input  1  force both channels to 0 for the next latched frame
vol_shift  input  VOL_W  arithmetic right-shift amount, 0..7
sample_tick  output  1  one-cycle pulse: a new sample pair was just latched (request for the next sample)
audio_mclk  output  1  master clock = clk/4 (25 MHz)
audio_sck  output  1  serial bit clock = clk/16 (6.25 MHz)
audio_lrck  output  1  word select = clk/1024; 0 = left, 1 = right
audio_sdin  output  1  serial data to the DAC

Behaviour:
- Reset: one clock `clk`; reset `rst` is asynchronous and active-high.
  - On reset: cnt=0, hold_l=hold_r=0, sample_tick=0, audio_sdin=0.
  - The clock outputs are flop bits of cnt, so they are also 0.
  - Reset mid-frame restarts at cnt=0 immediately and abandons the partial frame.
- Master counter: cnt[CNT_W-1:0] increments every clk and wraps 1023 -> 0.
  - audio_mclk = cnt[1], audio_sck = cnt[3], audio_lrck = cnt[9]. All are direct flop outputs, so they are glitch-free.
- SCK period index p = cnt[8:4], range 0..31 within each channel half.
  - Left half: cnt[9]=0. Right half: cnt[9]=1.
- Latch point: on the edge where cnt==1023, capture the processed audio_l and audio_r into hold_l and hold_r.
  - Processing: if mute, the held value is 0. Otherwise it is the input arithmetic-shifted right by vol_shift, sign-preserving, so 16'h8000 >>> 2 = 16'hE000.
  - mute and vol_shift are sampled at the latch point only.
  - Input changes at any other time have no effect on the frame in flight.
- sample_tick is registered and is high exactly in the cycle where cnt==0, i.e. one pulse per 1024 cycles.
- Data format: standard I2S with a one-SCK delay.
  - In the left half, during SCK period p: audio_sdin = hold_l[SAMPLE_W-p] for p=1..16, and 0 for p=0 and p=17..31.
  - The right half is the same using hold_r.
- Data timing:
  - audio_sdin is registered and changes only on SCK falling edges. Its update cycle is cnt[3:0]==4'hF, and it loads the bit for the upcoming period.
  - It is stable across every SCK rising edge (cnt[3:0]==4'h7 -> 8).
- After reset, the first frame (cnt 0..1023) transmits zeros. The first real data appears in frame 2.
- Sample latency: the input is present at cnt==1023. Its left MSB appears at cnt==16 of the next frame and its right MSB at cnt==528.

Decomposition:
- Shared package audio_pkg holds:
  - SAMPLE_W=16
  - CNT_W=10
  - the tap indices MCLK_BIT=1, SCK_BIT=3, LRCK_BIT=9
  - the constant LATCH_CNT=1023
  - typedef sample_t (signed [15:0])
- One sub-module is natural: i2s_clk_gen. It holds the counter and tap outputs and provides the latch and shift strobes.
- The shift/hold datapath stays in i2s_audio_tx.

Test Plan:
- Clock ratios: after reset, measure periods -> audio_mclk 4, audio_sck 16, audio_lrck 1024 clk cycles; 50% duty; sample_tick exactly every 1024 cycles at cnt==0.
- Serialization: audio_l=16'h8001, audio_r=16'h1234, vol_shift=0 held through frame 1.
  - Frame 2 left half, sdin at SCK rising edges p=0..31 -> 0, 1000000000000001, then fifteen 0s.
  - Right half -> 0, 0001001000110100, then 0s.
- Volume/mute: audio_l=16'h8000 with vol_shift=2 -> left word 16'hE000.
  - Same input with vol_shift=7 -> 16'hFF00.
  - mute=1 at latch -> all 32 right- and left-half bits 0.
- Latch isolation: change audio_l from 16'hAAAA to 16'h5555 at cnt==200 of frame 2 -> frame 2 still sends 16'hAAAA; frame 3 sends 16'h5555.
- Edge alignment: check every audio_sdin transition occurs only on a falling audio_sck edge and never within 7 clk cycles before a rising edge.
- Async reset mid-frame: assert rst at cnt==600 without a clk edge -> all outputs 0 immediately.
  - After release: cnt restarts at 0, the first frame is all zeros, and the first sample_tick occurs exactly 1024 cycles after release.

Source files
------------

// File: rtl/i2s_audio_tx_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
// Shared constants and types for the I2S audio transmitter.
//   SAMPLE_W  : PCM sample width, also the number of data bits per channel
//   CNT_W     : master counter width; one stereo frame = 2**CNT_W clk cycles
//   VOL_W     : width of the volume attenuation (right-shift) control
//   *_BIT     : master counter taps that directly drive the clock outputs
//   LATCH_CNT : counter value on whose closing edge a new sample pair is held
// ----------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int CNT_W    = 10;
    localparam int VOL_W    = 3;

    localparam int MCLK_BIT = 1;    // clk/4
    localparam int SCK_BIT  = 3;    // clk/16
    localparam int LRCK_BIT = 9;    // clk/1024

    // SCK periods per channel half are indexed by cnt[LRCK_BIT-1:SCK_BIT+1]
    localparam int PERIOD_W = LRCK_BIT - SCK_BIT - 1;
    // Width of a bit index into one sample
    localparam int IDX_W    = $clog2(SAMPLE_W);

    localparam logic [CNT_W-1:0] LATCH_CNT = {CNT_W{1'b1}};

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [PERIOD_W-1:0]        period_t;
    typedef logic [VOL_W-1:0]           vol_t;

endpackage

// File: rtl/i2s_audio_tx_if.sv
// ----------------------------------------------------------------------------
// i2s_audio_tx_if
// Bundles the sample-side bus and the Pmod I2S pins of the transmitter.
//   audio_l / audio_r : signed PCM samples from the mixer
//   mute              : zero both channels for the next latched frame
//   vol_shift         : arithmetic right-shift applied at the latch point
//   sample_tick       : one-cycle pulse after each latch (next-sample request)
//   audio_mclk/sck/lrck/sdin : CS4344 pins
// Modports:
//   master : the sample source (drives samples, observes tick and pins)
//   slave  : the transmitter
// ----------------------------------------------------------------------------
interface i2s_audio_tx_if;
    import audio_pkg::*;

    sample_t audio_l;
    sample_t audio_r;
    logic    mute;
    vol_t    vol_shift;
    logic    sample_tick;
    logic    audio_mclk;
    logic    audio_sck;
    logic    audio_lrck;
    logic    audio_sdin;

    modport master (
        output audio_l, audio_r, mute, vol_shift,
        input  sample_tick, audio_mclk, audio_sck, audio_lrck, audio_sdin
    );

    modport slave (
        input  audio_l, audio_r, mute, vol_shift,
        output sample_tick, audio_mclk, audio_sck, audio_lrck, audio_sdin
    );

endinterface

// File: rtl/i2s_audio_tx_clk_gen.sv
// ----------------------------------------------------------------------------
// i2s_clk_gen
// Free-running master counter for the I2S transmitter. The audio clocks are
// taps of the counter register, so they are glitch-free flop outputs.
// Ports:
//   clk, rst        : system clock, asynchronous active-high reset
//   o_mclk          : cnt[MCLK_BIT]  (clk/4)
//   o_sck           : cnt[SCK_BIT]   (clk/16)
//   o_lrck          : cnt[LRCK_BIT]  (clk/1024, 0 = left)
//   o_latch_stb     : high while cnt == LATCH_CNT (last cycle of a frame)
//   o_shift_stb     : high in the last clk of every SCK period (SCK about
//                     to fall), the only cycle in which serial data may change
//   o_next_right    : channel half of the SCK period that starts next
//   o_next_period   : index 0..31 of the SCK period that starts next
// ----------------------------------------------------------------------------
module i2s_clk_gen
    import audio_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    output logic    o_mclk,
    output logic    o_sck,
    output logic    o_lrck,
    output logic    o_latch_stb,
    output logic    o_shift_stb,
    output logic    o_next_right,
    output period_t o_next_period
);

    logic [CNT_W-1:0]         r_cnt;
    // {half, period} of the current SCK period plus one; only meaningful to
    // the datapath when o_shift_stb is high, where it names the next period.
    logic [CNT_W-SCK_BIT-2:0] w_upper_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_upper_next  = r_cnt[CNT_W-1:SCK_BIT+1] + 1'b1;

    assign o_mclk        = r_cnt[MCLK_BIT];
    assign o_sck         = r_cnt[SCK_BIT];
    assign o_lrck        = r_cnt[LRCK_BIT];

    assign o_latch_stb   = (r_cnt == LATCH_CNT);
    assign o_shift_stb   = &r_cnt[SCK_BIT:0];
    assign o_next_right  = w_upper_next[PERIOD_W];
    assign o_next_period = w_upper_next[PERIOD_W-1:0];

endmodule

// File: rtl/i2s_audio_tx.sv
// ----------------------------------------------------------------------------
// i2s_audio_tx
// Stereo I2S transmitter for the CS4344 Pmod DAC. Once per 1024-cycle frame
// it latches a processed sample pair (mute / volume shift) and serializes it
// MSB-first in standard I2S format (data delayed by one SCK after LRCK).
// Ports:
//   clk           : 100 MHz system clock
//   rst           : asynchronous, active-high reset
//   bus (slave)   : audio_l, audio_r, mute, vol_shift in;
//                   sample_tick, audio_mclk, audio_sck, audio_lrck,
//                   audio_sdin out
// Timing summary:
//   - samples, mute and vol_shift are sampled only on the edge leaving
//     cnt == 1023; sample_tick pulses in the following cycle (cnt == 0)
//   - audio_sdin updates only on SCK falling edges (cnt[3:0] == 4'hF -> 0)
//   - left MSB is on the wire from cnt 16, right MSB from cnt 528
// ----------------------------------------------------------------------------
module i2s_audio_tx
    import audio_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    i2s_audio_tx_if.slave  bus
);

    logic    w_latch_stb;
    logic    w_shift_stb;
    logic    w_next_right;
    period_t w_next_period;
    logic    w_next_bit;

    sample_t r_hold_l;
    sample_t r_hold_r;
    logic    r_tick;
    logic    r_sdin;

    // Mute wins over volume; >>> on a signed operand keeps the sign, so
    // negative samples attenuate towards -1 rather than towards 0.
    function automatic sample_t scale_sample(input sample_t s,
                                             input logic    m,
                                             input vol_t    sh);
        if (m) begin
            return '0;
        end
        return s >>> sh;
    endfunction

    // Bit carried by SCK period p of one channel half: period 0 is the I2S
    // one-bit delay, periods 1..SAMPLE_W carry MSB..LSB, the rest pad with 0.
    function automatic logic frame_bit(input sample_t h, input period_t p);
        logic [IDX_W-1:0] idx;
        if (p == '0 || p > period_t'(SAMPLE_W)) begin
            return 1'b0;
        end
        idx = IDX_W'(SAMPLE_W - int'(p));
        return h[idx];
    endfunction

    i2s_clk_gen u_clk_gen (
        .clk           (clk),
        .rst           (rst),
        .o_mclk        (bus.audio_mclk),
        .o_sck         (bus.audio_sck),
        .o_lrck        (bus.audio_lrck),
        .o_latch_stb   (w_latch_stb),
        .o_shift_stb   (w_shift_stb),
        .o_next_right  (w_next_right),
        .o_next_period (w_next_period)
    );

    // Hold registers: the frame in flight only ever sees these, so input
    // changes between latch points cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_l <= '0;
            r_hold_r <= '0;
        end else if (w_latch_stb) begin
            r_hold_l <= scale_sample(bus.audio_l, bus.mute, bus.vol_shift);
            r_hold_r <= scale_sample(bus.audio_r, bus.mute, bus.vol_shift);
        end
    end

    // Registered so the pulse lines up with cnt == 0, right after the latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_latch_stb;
        end
    end

    assign w_next_bit = w_next_right ? frame_bit(r_hold_r, w_next_period)
                                     : frame_bit(r_hold_l, w_next_period);

    // Loading on the SCK falling edge gives the DAC a full half period of
    // setup before it samples on the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sdin <= 1'b0;
        end else if (w_shift_stb) begin
            r_sdin <= w_next_bit;
        end
    end

    assign bus.sample_tick = r_tick;
    assign bus.audio_sdin  = r_sdin;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// ----------------------------------------------------------------------------
// tb_i2s_audio_tx
// Self-checking bench for i2s_audio_tx. A reference model derives every
// output from the cycle count since reset release and from the words held
// per frame (computed with integer floor division).
// ----------------------------------------------------------------------------
module tb_i2s_audio_tx;
    import audio_pkg::*;

    localparam int FRAME = 1024;
    localparam int MAXF  = 64;
    localparam int NVEC  = 7;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        mute;
        int          vol;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    i2s_audio_tx_if bus ();

    i2s_audio_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          ncyc;
    logic [15:0] exp_l [MAXF];
    logic [15:0] exp_r [MAXF];
    logic [15:0] cap_l [MAXF];
    logic [15:0] cap_r [MAXF];
    int          clk_err, tick_err, sdin_err, pad_err, align_err, first_bad;
    logic        prev_sdin, prev_sck;
    vec_t        tbl [NVEC];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, ncyc);
        end
    endtask

    // Arithmetic right shift expressed as floor division by 2**sh.
    function automatic logic [15:0] ref_scale(input logic [15:0] x, input logic m, input int sh);
        int v, d, q;
        if (m) return 16'h0000;
        v = int'($signed(x));
        d = 1 << sh;
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);
        return q[15:0];
    endfunction

    // Expected serial bit during frame cycle c given the frame's held words.
    function automatic logic ref_sdin(input int c, input logic [15:0] wl, input logic [15:0] wr);
        int p;
        logic [15:0] w;
        p = (c % 512) / 16;
        w = (c < 512) ? wl : wr;
        if (p < 1 || p > 16) return 1'b0;
        return w[16 - p];
    endfunction

    function automatic logic sel(input int which);
        case (which)
            0:       return bus.audio_mclk;
            1:       return bus.audio_sck;
            default: return bus.audio_lrck;
        endcase
    endfunction

    task automatic clear_frame_errs();
        clk_err = 0; tick_err = 0; sdin_err = 0; pad_err = 0; align_err = 0; first_bad = -1;
    endtask

    // Called once per clk, on the falling edge.
    task automatic monitor();
        int  c, f, p;
        logic e;
        if (rst) begin
            exp_l[0] = '0; exp_r[0] = '0; cap_l[0] = '0; cap_r[0] = '0;
            clear_frame_errs();
            prev_sdin = 1'b0; prev_sck = 1'b0;
            return;
        end
        c = ncyc % FRAME;
        f = ncyc / FRAME;
        if (f >= MAXF - 1) return;
        if (c == 0) begin
            cap_l[f] = '0; cap_r[f] = '0;
        end
        if (bus.audio_mclk !== (((c / 2) % 2) == 1) ||
            bus.audio_sck  !== (((c / 8) % 2) == 1) ||
            bus.audio_lrck !== (((c / 512) % 2) == 1)) begin
            clk_err++;
            if (first_bad < 0) first_bad = c;
        end
        if (bus.sample_tick !== (c == 0 && f > 0)) tick_err++;
        e = ref_sdin(c, exp_l[f], exp_r[f]);
        if (bus.audio_sdin !== e) begin
            sdin_err++;
            if (first_bad < 0) first_bad = c;
        end
        if (bus.audio_sdin !== prev_sdin && !(prev_sck === 1'b1 && bus.audio_sck === 1'b0))
            align_err++;
        if (c % 16 == 8) begin
            p = (c % 512) / 16;
            if (p >= 1 && p <= 16) begin
                if (c < 512) cap_l[f][16 - p] = bus.audio_sdin;
                else         cap_r[f][16 - p] = bus.audio_sdin;
            end else if (bus.audio_sdin !== 1'b0) begin
                pad_err++;
            end
        end
        prev_sdin = bus.audio_sdin;
        prev_sck  = bus.audio_sck;
        if (c == FRAME - 1) begin
            exp_l[f + 1] = ref_scale(bus.audio_l, bus.mute, int'(bus.vol_shift));
            exp_r[f + 1] = ref_scale(bus.audio_r, bus.mute, int'(bus.vol_shift));
            check("frame_left_word",  cap_l[f], exp_l[f]);
            check("frame_right_word", cap_r[f], exp_r[f]);
            check("clock_tap_bad_cycles", clk_err, 0);
            check("tick_bad_cycles", tick_err, 0);
            check("sdin_bad_cycles", sdin_err, 0);
            check("sdin_pad_bits_nonzero", pad_err, 0);
            check("sdin_change_off_sck_fall", align_err, 0);
            if (first_bad >= 0)
                $display("  first bad frame cycle %0d in frame %0d", first_bad, f);
            clear_frame_errs();
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) ncyc = 0;
        else     ncyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic run_to(input int target);
        int g;
        g = 0;
        while (ncyc != target) begin
            step();
            g++;
            if (g > 3 * FRAME) begin
                check("run_to_timeout", ncyc, target);
                return;
            end
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst  = 1'b0;
        ncyc = 0;
        monitor();
    endtask

    task automatic measure(input int which, output int period, output int high);
        logic prev, cur;
        int   r1, hi, g;
        r1 = -1; period = -1; high = -1; hi = 0; g = 0;
        prev = sel(which);
        while (g < 3000) begin
            step();
            g++;
            cur = sel(which);
            if (prev === 1'b0 && cur === 1'b1) begin
                if (r1 < 0) begin
                    r1 = ncyc;
                    hi = 1;
                end else begin
                    period = ncyc - r1;
                    high   = hi;
                    return;
                end
            end else if (r1 >= 0 && cur === 1'b1) begin
                hi++;
            end
            prev = cur;
        end
    endtask

    task automatic wait_tick(output int at);
        int g;
        at = -1;
        g  = 0;
        while (g < 2100) begin
            if (bus.sample_tick === 1'b1) begin
                at = ncyc;
                return;
            end
            step();
            g++;
        end
    endtask

    task automatic drive(input logic [15:0] l, input logic [15:0] r, input logic m, input int v);
        bus.audio_l   = l;
        bus.audio_r   = r;
        bus.mute      = m;
        bus.vol_shift = 3'(v);
    endtask

    initial begin
        int per, hi, t1, t2, f0, g, h;

        tbl[0] = '{16'h8001, 16'h1234, 1'b0, 0, 16'h8001, 16'h1234};
        tbl[1] = '{16'h8000, 16'h8000, 1'b0, 2, 16'hE000, 16'hE000};
        tbl[2] = '{16'h8000, 16'h7FFF, 1'b0, 7, 16'hFF00, 16'h00FF};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b1, 3, 16'h0000, 16'h0000};
        tbl[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 1, 16'h3FFF, 16'hFFFF};
        tbl[5] = '{16'hC000, 16'h4000, 1'b0, 4, 16'hFC00, 16'h0400};
        tbl[6] = '{16'h1234, 16'h8001, 1'b0, 0, 16'h1234, 16'h8001};

        checks = 0; errors = 0; ncyc = 0;
        clear_frame_errs();
        rst = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0, 0);

        // Reset state
        repeat (3) step();
        check("reset_sample_tick", bus.sample_tick, 0);
        check("reset_mclk", bus.audio_mclk, 0);
        check("reset_sck", bus.audio_sck, 0);
        check("reset_lrck", bus.audio_lrck, 0);
        check("reset_sdin", bus.audio_sdin, 0);

        release_rst();

        // Clock ratios and duty
        measure(0, per, hi);
        check("mclk_period", per, 4);
        check("mclk_high", hi, 2);
        measure(1, per, hi);
        check("sck_period", per, 16);
        check("sck_high", hi, 8);
        measure(2, per, hi);
        check("lrck_period", per, 1024);
        check("lrck_high", hi, 512);

        wait_tick(t1);
        check("tick_at_frame_start", t1 % FRAME, 0);
        step();
        wait_tick(t2);
        check("tick_interval", t2 - t1, FRAME);

        // Table-driven: vector i set during frame f0+i, on the wire in f0+i+1
        f0 = ncyc / FRAME + 1;
        for (int i = 0; i < NVEC + 2; i++) begin
            run_to((f0 + i) * FRAME);
            if (i < NVEC) drive(tbl[i].l, tbl[i].r, tbl[i].mute, tbl[i].vol);
            if (i >= 2) begin
                check($sformatf("vec%0d_left", i - 2),  cap_l[f0 + i - 1], tbl[i - 2].el);
                check($sformatf("vec%0d_right", i - 2), cap_r[f0 + i - 1], tbl[i - 2].er);
            end
        end

        // Latch isolation: change mid-frame must wait for the next latch
        g = ncyc / FRAME;
        drive(16'hAAAA, 16'h0F0F, 1'b0, 0);
        run_to((g + 1) * FRAME + 200);
        bus.audio_l = 16'h5555;
        run_to((g + 2) * FRAME);
        check("isolation_old_word", cap_l[g + 1], 16'hAAAA);
        check("isolation_right", cap_r[g + 1], 16'h0F0F);
        run_to((g + 3) * FRAME);
        check("isolation_new_word", cap_l[g + 2], 16'h5555);

        // Randomized frames, checked frame by frame by the monitor
        g = ncyc / FRAME;
        for (int k = 0; k < 10; k++) begin
            run_to((g + k) * FRAME);
            drive(16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)));
            run_to((g + k) * FRAME + int'($urandom_range(100, 900)));
            drive(16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)));
        end

        // Asynchronous reset at cnt 600 of a frame carrying all-ones
        h = ncyc / FRAME + 1;
        run_to(h * FRAME);
        drive(16'hFFFF, 16'hFFFF, 1'b0, 0);
        run_to((h + 1) * FRAME + 600);
        check("pre_reset_sdin", bus.audio_sdin, 1);
        check("pre_reset_lrck", bus.audio_lrck, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sample_tick", bus.sample_tick, 0);
        check("async_rst_mclk", bus.audio_mclk, 0);
        check("async_rst_sck", bus.audio_sck, 0);
        check("async_rst_lrck", bus.audio_lrck, 0);
        check("async_rst_sdin", bus.audio_sdin, 0);
        repeat (2) step();
        release_rst();
        wait_tick(t1);
        check("first_tick_after_release", t1, FRAME);
        check("post_reset_frame0_left", cap_l[0], 16'h0000);
        check("post_reset_frame0_right", cap_r[0], 16'h0000);
        run_to(2 * FRAME);
        check("post_reset_frame1_left", cap_l[1], 16'hFFFF);
        check("post_reset_frame1_right", cap_r[1], 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
